// File: rtl/life_pkg.sv
// Shared types and constants for the Game of Life generation sequencer.
package life_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_ACC   = 3'd2,
    ST_WRITE = 3'd3,
    ST_SWAP  = 3'd4
  } life_state_t;

  localparam logic [2:0] ALIVE_COLOUR_DEF = 3'b111;
  localparam logic [2:0] DEAD_COLOUR_DEF  = 3'b000;

  // Neighbour index of the centre cell and of the last neighbour read.
  localparam logic [3:0] NB_SELF = 4'd4;
  localparam logic [3:0] NB_LAST = 4'd8;

  // Neighbour offset table, raster order (-1,-1)..(+1,+1).
  // Offsets are 2-bit two's complement: 2'b11 = -1, 2'b00 = 0, 2'b01 = +1.
  function automatic logic [1:0] nb_dx(input logic [3:0] k);
    case (k)
      4'd0, 4'd3, 4'd6: nb_dx = 2'b11;
      4'd2, 4'd5, 4'd8: nb_dx = 2'b01;
      default:          nb_dx = 2'b00;
    endcase
  endfunction

  function automatic logic [1:0] nb_dy(input logic [3:0] k);
    case (k)
      4'd0, 4'd1, 4'd2: nb_dy = 2'b11;
      4'd6, 4'd7, 4'd8: nb_dy = 2'b01;
      default:          nb_dy = 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/life_gen_sched_rule.sv
// Conway life rule: a cell lives next generation with exactly 3 neighbours,
// or with 2 neighbours if it is already alive.
module life_rule (
  input  logic       self,
  input  logic [3:0] n,
  output logic       next
);

  // Pure combinational birth/survival decision.
  always_comb begin
    next = (n == 4'd3) | (self & (n == 4'd2));
  end

endmodule

// File: rtl/life_gen_sched.sv
// Sequences one life generation over a double-buffered cell memory:
// nine neighbour reads per cell, rule evaluation, write-back and plot.
module life_gen_sched
  import life_pkg::*;
#(
  parameter int unsigned GRID_W       = 8,
  parameter int unsigned GRID_H       = 8,
  parameter logic [2:0]  ALIVE_COLOUR = ALIVE_COLOUR_DEF,
  parameter logic [2:0]  DEAD_COLOUR  = DEAD_COLOUR_DEF,
  localparam int unsigned XW = $clog2(GRID_W),
  localparam int unsigned YW = $clog2(GRID_H)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          step,
  input  logic          run,
  output logic          busy,
  output logic          done,
  output logic          buf_sel,
  output logic          rd_en,
  output logic [XW-1:0] rd_x,
  output logic [YW-1:0] rd_y,
  input  logic          rd_data,
  output logic          wr_en,
  output logic [XW-1:0] wr_x,
  output logic [YW-1:0] wr_y,
  output logic          wr_data,
  output logic          plot_en,
  output logic [XW-1:0] plot_x,
  output logic [YW-1:0] plot_y,
  output logic [2:0]    plot_colour
);

  life_state_t   state_q, state_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic [3:0]    k_q, k_d;
  logic [3:0]    n_q, n_d;
  logic          self_q, self_d;
  logic          buf_sel_q, buf_sel_d;
  // Tracks the read issued last cycle so its data can be attributed to the right k.
  logic          rd_pend_q, rd_pend_d;
  logic [3:0]    rd_k_q, rd_k_d;

  logic          next_val;
  logic [1:0]    dx, dy;

  life_rule u_rule (
    .self (self_q),
    .n    (n_q),
    .next (next_val)
  );

  // Next-state, coordinate walk and read-data accumulation.
  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    k_d       = k_q;
    n_d       = n_q;
    self_d    = self_q;
    buf_sel_d = buf_sel_q;
    rd_pend_d = (state_q == ST_READ);
    rd_k_d    = k_q;

    if (rd_pend_q) begin
      if (rd_k_q == NB_SELF) self_d = rd_data;
      else                   n_d    = n_q + {3'b000, rd_data};
    end

    case (state_q)
      ST_IDLE: begin
        if (step | run) begin
          state_d = ST_READ;
          x_d     = '0;
          y_d     = '0;
          k_d     = '0;
          n_d     = '0;
        end
      end
      ST_READ: begin
        if (k_q == NB_LAST) state_d = ST_ACC;
        else                k_d     = k_q + 4'd1;
      end
      ST_ACC: begin
        state_d = ST_WRITE;
      end
      ST_WRITE: begin
        n_d = '0;
        k_d = '0;
        x_d = x_q + 1'b1;
        if (x_q == '1) y_d = y_q + 1'b1;
        // Power-of-two grid: x/y roll back to 0 after the last cell.
        if ((x_q == '1) && (y_q == '1)) state_d = ST_SWAP;
        else                            state_d = ST_READ;
      end
      ST_SWAP: begin
        buf_sel_d = ~buf_sel_q;
        state_d   = run ? ST_READ : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs decoded from registered state; everything is zero when idle.
  always_comb begin
    dx          = nb_dx(k_q);
    dy          = nb_dy(k_q);
    busy        = (state_q != ST_IDLE);
    done        = (state_q == ST_SWAP);
    buf_sel     = buf_sel_q;
    rd_en       = 1'b0;
    rd_x        = '0;
    rd_y        = '0;
    wr_en       = 1'b0;
    wr_x        = '0;
    wr_y        = '0;
    wr_data     = 1'b0;
    plot_en     = 1'b0;
    plot_x      = '0;
    plot_y      = '0;
    plot_colour = '0;
    if (state_q == ST_READ) begin
      rd_en = 1'b1;
      rd_x  = x_q + {{(XW-1){dx[1]}}, dx[0]};
      rd_y  = y_q + {{(YW-1){dy[1]}}, dy[0]};
    end
    if (state_q == ST_WRITE) begin
      wr_en       = 1'b1;
      wr_x        = x_q;
      wr_y        = y_q;
      wr_data     = next_val;
      plot_en     = 1'b1;
      plot_x      = x_q;
      plot_y      = y_q;
      plot_colour = next_val ? ALIVE_COLOUR : DEAD_COLOUR;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      x_q       <= '0;
      y_q       <= '0;
      k_q       <= '0;
      n_q       <= '0;
      self_q    <= 1'b0;
      buf_sel_q <= 1'b0;
      rd_pend_q <= 1'b0;
      rd_k_q    <= '0;
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      y_q       <= y_d;
      k_q       <= k_d;
      n_q       <= n_d;
      self_q    <= self_d;
      buf_sel_q <= buf_sel_d;
      rd_pend_q <= rd_pend_d;
      rd_k_q    <= rd_k_d;
    end
  end

endmodule

// File: tb/tb_life_gen_sched.sv
// Self-checking bench for life_gen_sched on an 8x8 grid with a 1-cycle RAM model.
module tb_life_gen_sched;

  typedef struct {
    logic [2:0] x;
    logic [2:0] y;
    logic       d;
  } exp_t;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       step  = 1'b0;
  logic       run   = 1'b0;
  logic       busy, done, buf_sel, rd_en, rd_data, wr_en, wr_data, plot_en;
  logic [2:0] rd_x, rd_y, wr_x, wr_y, plot_x, plot_y, plot_colour;
  logic [27:0] all_out;

  logic [63:0] mem [2];
  logic        ld_en = 1'b0;
  logic [63:0] ld_val = '0;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   plot_cnt = 0;
  int   alive_cnt = 0;

  life_gen_sched #(
    .GRID_W       (8),
    .GRID_H       (8),
    .ALIVE_COLOUR (3'b111),
    .DEAD_COLOUR  (3'b000)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .step        (step),
    .run         (run),
    .busy        (busy),
    .done        (done),
    .buf_sel     (buf_sel),
    .rd_en       (rd_en),
    .rd_x        (rd_x),
    .rd_y        (rd_y),
    .rd_data     (rd_data),
    .wr_en       (wr_en),
    .wr_x        (wr_x),
    .wr_y        (wr_y),
    .wr_data     (wr_data),
    .plot_en     (plot_en),
    .plot_x      (plot_x),
    .plot_y      (plot_y),
    .plot_colour (plot_colour)
  );

  assign all_out = {busy, done, buf_sel, rd_en, rd_x, rd_y, wr_en, wr_x, wr_y,
                    wr_data, plot_en, plot_x, plot_y, plot_colour};

  always #5 clock = ~clock;

  // Cell RAM: 1-cycle read from buf_sel, write into the other buffer.
  always @(posedge clock) begin
    if (ld_en) begin
      mem[0] <= ld_val;
      mem[1] <= '0;
    end else begin
      if (rd_en) rd_data <= mem[buf_sel][{rd_y, rd_x}];
      if (wr_en) mem[~buf_sel][{wr_y, wr_x}] <= wr_data;
    end
  end

  // Scoreboard consumer: every write/plot is checked against the golden queue.
  always @(negedge clock) begin
    exp_t        e;
    logic [16:0] obs, expv;
    if (reset && plot_en) begin
      plot_cnt++;
      if (plot_colour == 3'b111) alive_cnt++;
    end
    if (reset && wr_en) begin
      n_checks++;
      obs = {wr_x, wr_y, wr_data, plot_en, plot_x, plot_y, plot_colour};
      if (sb.size() == 0) begin
        $display("FAIL sb_unexpected_write: got x=%0d y=%0d d=%0d, required no write", wr_x, wr_y, wr_data);
      end else begin
        e = sb.pop_front();
        expv = {e.x, e.y, e.d, 1'b1, e.x, e.y, (e.d ? 3'b111 : 3'b000)};
        if (obs !== expv)
          $display("FAIL sb_write: got %h required %h", obs, expv);
        else
          n_pass++;
      end
    end
  end

  function automatic int idx(input int x, input int y);
    return y * 8 + x;
  endfunction

  function automatic logic [63:0] gold_next(input logic [63:0] g);
    logic [63:0] r;
    int cnt;
    r = '0;
    for (int y = 0; y < 8; y++) begin
      for (int x = 0; x < 8; x++) begin
        cnt = 0;
        for (int dy = -1; dy <= 1; dy++)
          for (int dx = -1; dx <= 1; dx++)
            if (dx != 0 || dy != 0)
              cnt += int'(g[idx((x + dx + 8) % 8, (y + dy + 8) % 8)]);
        r[idx(x, y)] = (cnt == 3) || (g[idx(x, y)] && cnt == 2);
      end
    end
    return r;
  endfunction

  task automatic push_gen(input logic [63:0] g, output logic [63:0] nx);
    exp_t e;
    nx = gold_next(g);
    for (int y = 0; y < 8; y++)
      for (int x = 0; x < 8; x++) begin
        e.x = 3'(x);
        e.y = 3'(y);
        e.d = nx[idx(x, y)];
        sb.push_back(e);
      end
  endtask

  // Reset the DUT, load buffer 0 with g, clear buffer 1; returns at a negedge.
  task automatic start_fresh(input logic [63:0] g);
    @(negedge clock);
    reset = 1'b0;
    step  = 1'b0;
    run   = 1'b0;
    sb.delete();
    ld_val = g;
    ld_en  = 1'b1;
    @(posedge clock);
    #1 ld_en = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
  endtask

  // Pulse step and wait (bounded) for done; c is the cycle done was seen.
  task automatic run_step(output int c, output int dn);
    step = 1'b1;
    c = 0;
    dn = 0;
    while (dn == 0 && c < 800) begin
      @(negedge clock);
      step = 1'b0;
      c++;
      if (done) dn = 1;
    end
  endtask

  task automatic test_reset();
    #2 reset = 1'b0;
    #1;
    n_checks++;
    if (all_out !== 28'h0) $display("FAIL reset_outputs: got %h required 0", all_out);
    else n_pass++;
    @(negedge clock);
    reset = 1'b1;
    repeat (5) @(negedge clock);
    n_checks++;
    if (busy !== 1'b0 || buf_sel !== 1'b0) $display("FAIL reset_idle: got busy=%b buf_sel=%b required 0 0", busy, buf_sel);
    else n_pass++;
  endtask

  task automatic test_blinker();
    logic [63:0] g, vert, nx;
    int c, dn;
    g = '0;
    g[idx(3, 4)] = 1'b1; g[idx(4, 4)] = 1'b1; g[idx(5, 4)] = 1'b1;
    vert = '0;
    vert[idx(4, 3)] = 1'b1; vert[idx(4, 4)] = 1'b1; vert[idx(4, 5)] = 1'b1;
    start_fresh(g);
    push_gen(g, nx);
    plot_cnt = 0;
    alive_cnt = 0;
    run_step(c, dn);
    n_checks++;
    if (dn != 1 || c != 705) $display("FAIL blinker_done_cycle: got %0d required 705", c);
    else n_pass++;
    @(negedge clock);
    n_checks++;
    if (buf_sel !== 1'b1 || busy !== 1'b0) $display("FAIL blinker_after: got buf_sel=%b busy=%b required 1 0", buf_sel, busy);
    else n_pass++;
    n_checks++;
    if (mem[1] !== vert) $display("FAIL blinker_buffer: got %h required %h", mem[1], vert);
    else n_pass++;
    n_checks++;
    if (plot_cnt != 64) $display("FAIL blinker_plots: got %0d required 64", plot_cnt);
    else n_pass++;
    n_checks++;
    if (alive_cnt != 3) $display("FAIL blinker_alive_plots: got %0d required 3", alive_cnt);
    else n_pass++;
    n_checks++;
    if (sb.size() != 0) $display("FAIL blinker_sb_left: got %0d required 0", sb.size());
    else n_pass++;
  endtask

  task automatic test_wrap();
    logic [63:0] g, gi, nx;
    int c, dn, gap;
    g = '0;
    g[idx(7, 6)] = 1'b1; g[idx(0, 7)] = 1'b1; g[idx(6, 0)] = 1'b1;
    g[idx(7, 0)] = 1'b1; g[idx(0, 0)] = 1'b1;
    start_fresh(g);
    gi = g;
    for (int i = 0; i < 4; i++) begin
      push_gen(gi, nx);
      gi = nx;
    end
    run = 1'b1;
    c = 0; dn = 0; gap = 0;
    while (dn < 4 && c < 3000) begin
      @(negedge clock);
      c++;
      if (c == 1) begin
        n_checks++;
        if (rd_en !== 1'b1 || rd_x !== 3'd7 || rd_y !== 3'd7)
          $display("FAIL wrap_first_addr: got en=%b (%0d,%0d) required 1 (7,7)", rd_en, rd_x, rd_y);
        else n_pass++;
      end
      if (c == 2200) run = 1'b0;
      if (!busy) gap = 1;
      if (done) dn++;
    end
    n_checks++;
    if (dn != 4 || c != 2820) $display("FAIL wrap_done: got dn=%0d c=%0d required 4 2820", dn, c);
    else n_pass++;
    n_checks++;
    if (gap != 0) $display("FAIL wrap_busy_gap: got %0d required 0", gap);
    else n_pass++;
    @(negedge clock);
    n_checks++;
    if (busy !== 1'b0 || buf_sel !== 1'b0) $display("FAIL wrap_after: got busy=%b buf_sel=%b required 0 0", busy, buf_sel);
    else n_pass++;
    n_checks++;
    if (mem[0] !== gi) $display("FAIL wrap_grid: got %h required %h", mem[0], gi);
    else n_pass++;
  endtask

  task automatic test_blocked_step();
    logic [63:0] g, nx;
    int c, dn, donec;
    logic b706, b720;
    g = {$urandom, $urandom};
    start_fresh(g);
    push_gen(g, nx);
    step = 1'b1;
    c = 0; dn = 0; donec = 0; b706 = 1'bx; b720 = 1'bx;
    while (c < 720) begin
      @(negedge clock);
      c++;
      step = (c == 200);
      if (done) begin dn++; donec = c; end
      if (c == 706) b706 = busy;
      if (c == 720) b720 = busy;
    end
    n_checks++;
    if (dn != 1 || donec != 705) $display("FAIL blocked_done: got dn=%0d at %0d required 1 at 705", dn, donec);
    else n_pass++;
    n_checks++;
    if (b706 !== 1'b0 || b720 !== 1'b0) $display("FAIL blocked_idle: got busy706=%b busy720=%b required 0 0", b706, b720);
    else n_pass++;
    n_checks++;
    if (sb.size() != 0) $display("FAIL blocked_sb_left: got %0d required 0", sb.size());
    else n_pass++;
  endtask

  task automatic test_run_drop();
    logic [63:0] g, g1, g2;
    int c, dn, donec;
    g = {$urandom, $urandom};
    start_fresh(g);
    push_gen(g, g1);
    push_gen(g1, g2);
    run = 1'b1;
    c = 0; dn = 0; donec = 0;
    while (c < 1500) begin
      @(negedge clock);
      c++;
      if (c == 1005) run = 1'b0;
      if (done) begin dn++; donec = c; end
    end
    n_checks++;
    if (dn != 2 || donec != 1410) $display("FAIL rundrop_done: got dn=%0d last=%0d required 2 1410", dn, donec);
    else n_pass++;
    n_checks++;
    if (busy !== 1'b0 || buf_sel !== 1'b0) $display("FAIL rundrop_after: got busy=%b buf_sel=%b required 0 0", busy, buf_sel);
    else n_pass++;
    n_checks++;
    if (mem[0] !== g2) $display("FAIL rundrop_grid: got %h required %h", mem[0], g2);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic [63:0] g, nx;
    int c, dn;
    g = {$urandom, $urandom};
    start_fresh(g);
    push_gen(g, nx);
    step = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clock);
      step = 1'b0;
    end
    n_checks++;
    if (rd_en !== 1'b1) $display("FAIL resetmid_pre: got rd_en=%b required 1", rd_en);
    else n_pass++;
    reset = 1'b0;
    #1;
    n_checks++;
    if (all_out !== 28'h0) $display("FAIL resetmid_outputs: got %h required 0", all_out);
    else n_pass++;
    sb.delete();
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    push_gen(g, nx);
    run_step(c, dn);
    n_checks++;
    if (dn != 1 || c != 705) $display("FAIL resetmid_regen: got %0d required 705", c);
    else n_pass++;
    @(negedge clock);
    n_checks++;
    if (buf_sel !== 1'b1 || mem[1] !== nx) $display("FAIL resetmid_result: got buf_sel=%b grid=%h required 1 %h", buf_sel, mem[1], nx);
    else n_pass++;
  endtask

  task automatic test_static();
    logic [63:0] g, nx;
    int c, dn;
    start_fresh(64'h0);
    push_gen(64'h0, nx);
    run_step(c, dn);
    @(negedge clock);
    n_checks++;
    if (dn != 1 || mem[1] !== 64'h0) $display("FAIL static_empty: got dn=%0d grid=%h required 1 0", dn, mem[1]);
    else n_pass++;
    g = '0;
    g[idx(0, 0)] = 1'b1; g[idx(7, 0)] = 1'b1; g[idx(0, 7)] = 1'b1; g[idx(7, 7)] = 1'b1;
    start_fresh(g);
    push_gen(g, nx);
    run_step(c, dn);
    @(negedge clock);
    n_checks++;
    if (dn != 1 || c != 705 || mem[1] !== g) $display("FAIL static_block: got c=%0d grid=%h required 705 %h", c, mem[1], g);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_blinker();
    test_wrap();
    test_blocked_step();
    test_run_drop();
    test_reset_mid();
    test_static();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/life_gen_sched.md
# life_gen_sched

- Sequences one Game of Life generation update over a `GRID_W` x `GRID_H` double-buffered cell memory.
- For each cell in raster order it:
  - reads the cell and its 8 toroidal neighbours from the current buffer;
  - applies the life rule;
  - writes the result to the other buffer;
  - issues a one-cycle plot request to the VGA plotter.
- Sits between the user-input control FSM, which raises `step`/`run`, and the cell RAM plus the plotter.

## Interface
Parameters:
- `GRID_W`, 8: grid width in cells. Power of two, ≥4.
- `GRID_H`, 8: grid height in cells. Power of two, ≥4.
- `ALIVE_COLOUR`, 3'b111: plot colour for a live cell.
- `DEAD_COLOUR`, 3'b000: plot colour for a dead cell.
- Derived localparams: `XW = $clog2(GRID_W)`, `YW = $clog2(GRID_H)`.

Ports (all control outputs are active-high):
- `clock` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low.
- `step` in 1: request one generation. Sampled only in IDLE.
- `run` in 1: level. When high, generations repeat back-to-back.
- `busy` out 1: high in every non-IDLE state.
- `done` out 1: one-cycle pulse in SWAP.
- `buf_sel` out 1: current (read) buffer. The write buffer is `~buf_sel`.
- `rd_en` out 1: memory read strobe.
- `rd_x` out XW, `rd_y` out YW: read address.
- `rd_data` in 1: cell value. Valid the cycle after `rd_en`.
- `wr_en` out 1, `wr_x` out XW, `wr_y` out YW, `wr_data` out 1: write port into buffer `~buf_sel`.
- `plot_en` out 1, `plot_x` out XW, `plot_y` out YW, `plot_colour` out 3: plotter request.

## Operation
States: IDLE, READ, ACC, WRITE, SWAP.

- **IDLE**
  - `step | run` → READ, with x=0, y=0, k=0, n=0.
  - Otherwise stay in IDLE.
- **READ**
  - Asserts `rd_en` with the neighbour address for index k.
  - k=0..8 selects (dx,dy) in raster order from (-1,-1) to (+1,+1); k=4 is the cell itself.
  - Coordinates wrap modulo `GRID_W`/`GRID_H`: x-1 at x=0 gives `GRID_W-1`; x+1 at `GRID_W-1` gives 0. Same rule for y.
  - k increments each cycle.
  - After k=8 → ACC.
- **Data capture (READ and ACC)**
  - Every cycle after a read, `rd_data` is captured.
  - For k≠4 the captured value adds to the 4-bit neighbour count n.
  - For k=4 it loads `self`.
- **ACC**
  - Captures the k=8 data only.
  - → WRITE.
- **WRITE** (one cycle)
  - `next = (n==3) | (self & n==2)`.
  - `wr_en=1` and `plot_en=1` at (x,y).
  - `wr_data=next`.
  - `plot_colour` is `ALIVE_COLOUR` if `next` is 1, else `DEAD_COLOUR`.
  - Then advance to the next cell, clear n and k:
    - x increments;
    - when x wraps, y increments;
    - on the last cell (`GRID_W-1`, `GRID_H-1`) → SWAP, otherwise → READ.
- **SWAP** (one cycle)
  - `done=1`.
  - `buf_sel` toggles at the end of the cycle.
  - `run` high → READ of cell (0,0); otherwise → IDLE.
- **Ignored requests**: `step` outside IDLE is ignored and is not queued.
- **run dropped mid-generation**: the current generation completes, then the block returns to IDLE.
- **Reset**: asynchronous assert from any state, mid-generation included:
  - state goes to IDLE;
  - `buf_sel=0`; x, y, k, n, `self` = 0;
  - every output is 0;
  - a partially written buffer is abandoned, with no SWAP.

## Timing
- Address and strobe outputs are combinational from registered state/x/y/k.
- `wr_data` and `plot_colour` are combinational from registered n and `self`.
- Cycles per cell: 11, made up of 9 READ, 1 ACC and 1 WRITE.
- A generation takes `11*GRID_W*GRID_H + 1` busy cycles.
  - Cycle 1 is the first READ after the `step` edge.
  - SWAP is the last cycle.
  - For 8x8 this is 705 cycles.
- First write/plot (cell 0,0): cycle 11. Last: cycle `11*W*H`.
- `rd_data` is sampled exactly one cycle after its `rd_en`. The memory has a fixed 1-cycle read latency, with no stall input.
- New `buf_sel` is visible in the first cycle after SWAP.

## Structure
- Package `life_pkg` holds:
  - the state encoding `life_state_t` (IDLE=0, READ=1, ACC=2, WRITE=3, SWAP=4; 3 bits);
  - the neighbour offset table (k → dx,dy);
  - the colour defaults.
- One combinational sub-module, `life_rule`: inputs `self` and n[3:0], output `next`.
- All wrap arithmetic is done at XW/YW width, so it wraps naturally because the grid dimensions are powers of two.

## Test plan
Unless stated otherwise, the bench uses an 8x8 grid with a 1-cycle-latency RAM model.

1. **Blinker**: horizontal blinker at (3,4),(4,4),(5,4), one `step`.
   - Buffer 1 holds the vertical blinker (4,3),(4,4),(4,5).
   - `done` fires at cycle 705 and `buf_sel` becomes 1.
   - Exactly 64 `plot_en` pulses, 3 of them with colour 3'b111.
2. **Toroidal wrap**: glider crossing the corner at (7,7).
   - 4 generations under `run` match the golden model.
   - At cell (0,0), k=0 reads address (7,7).
   - `busy` stays high with no IDLE gap between generations.
3. **Blocked step**: `step` pulsed at cycle 200 during a generation.
   - Ignored.
   - Exactly one `done`; IDLE at cycle 706.
4. **run drop**: `run` deasserted mid-generation-2.
   - Generation 2 completes.
   - `done` count is 2, then IDLE.
   - Final `buf_sel` is 0.
5. **Reset mid-operation**: `reset` low at cycle 300.
   - All outputs are 0 immediately, asynchronously.
   - State is IDLE and `buf_sel=0`.
   - A subsequent `step` runs a full 705-cycle generation.
6. **Static cases**: an empty grid stays empty; a 2x2 block at (0,0),(7,0),(0,7),(7,7) (wrapped) stays stable.
   - Every WRITE's `wr_data` matches `life_rule` applied to the golden neighbour count.
